// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the prefetching fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Opcode (top nibble of an instruction) that stops sequential fetching
    localparam logic [3:0] HLT_OP = 4'hF;

    // Byte distance between sequential instructions
    localparam int unsigned PC_INC = 2;

    // Default datapath widths used by the entry type below
    localparam int unsigned FETCH_ADDR_W  = 16;
    localparam int unsigned FETCH_INSTR_W = 16;

    // One prefetch queue entry: the instruction and the PC it was fetched from
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous DEPTH-entry FIFO with push, pop and flush.
//               Flush wins over push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];

    // Overflow/underflow attempts are ignored rather than corrupting state
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch
// Description : Instruction-fetch stage with a prefetch queue. Issues
//               sequential fetches with one request in flight, queues the
//               returned {pc, instr} pairs and hands them to decode under a
//               valid/ready handshake. Decode redirects flush and refetch;
//               a HLT opcode stops fetching until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_outstanding;
    logic               r_squash;
    logic               r_halted;

    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic [ENTRY_W-1:0] w_head;
    logic               w_hlt_resp;
    logic               w_accept;
    logic               w_room;
    logic               w_pop;

    assign w_hlt_resp = imem_valid && (imem_data[INSTR_W-1 -: 4] == HLT_OP);

    // A response is kept only if it answers a live, unsquashed request
    assign w_accept   = imem_valid && r_outstanding && !r_squash && !redirect;

    // Queue slots already promised to in-flight requests count as used, so a
    // response always finds space
    assign w_room     = !w_full && ((w_count + CNT_W'(r_outstanding)) < CNT_W'(DEPTH));

    // A returning response (live or squashed) frees the single request slot in
    // the same cycle, which keeps 1-cycle memory at one fetch per cycle and
    // lets the post-redirect fetch go out as the squashed response lands
    assign imem_req   = !rst && !redirect && !r_halted
                        && (!r_squash || imem_valid)
                        && (!r_outstanding || imem_valid)
                        && w_room
                        && !w_hlt_resp;
    assign imem_addr  = r_fetch_pc;

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? '0 : w_head[INSTR_W-1:0];
    assign instr_pc    = w_empty ? '0 : w_head[ENTRY_W-1:INSTR_W];
    assign w_pop       = instr_valid && instr_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .flush (redirect),
        .wdata ({r_req_pc, imem_data}),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Fetch PC, in-flight tracking, squash and halt control; redirect first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_squash      <= 1'b0;
            r_halted      <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_halted   <= 1'b0;
            if (r_outstanding && !imem_valid) begin
                r_squash <= 1'b1;
            end else begin
                r_squash      <= 1'b0;
                r_outstanding <= 1'b0;
            end
        end else begin
            if (imem_req) begin
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(PC_INC);
                r_req_pc      <= r_fetch_pc;
                r_outstanding <= 1'b1;
            end else if (imem_valid) begin
                r_outstanding <= 1'b0;
            end
            if (imem_valid) begin
                r_squash <= 1'b0;
            end
            if (w_accept && w_hlt_resp) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch
// Description : Self-checking bench for fetch_prefetch: vector table, directed
//               corner sequences and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;
    import fetch_pkg::*;

    localparam int unsigned       ADDR_W   = 16;
    localparam int unsigned       INSTR_W  = 16;
    localparam int unsigned       DEPTH    = 4;
    localparam logic [15:0]       RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue of fetched entries plus fetch state
    fetch_entry_t q[$];
    logic [15:0]  m_pc;
    logic [15:0]  m_opc;
    bit           m_out;
    bit           m_sq;
    bit           m_halt;

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_opc  = '0;
        m_out  = 0;
        m_sq   = 0;
        m_halt = 0;
    endtask

    // Memory: one request at a time, answered after lat cycles
    bit          mbusy = 0;
    int          mrem = 0;
    logic [15:0] maddr = '0;
    int          lat = 1;
    bit          rand_lat = 0;
    logic [15:0] hlt_addr = 16'h0001;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == hlt_addr) return 16'hF000;
        return (a * 16'd3 + 16'h0105) & 16'h7FFF;
    endfunction

    bit          cap_req, cap_ivalid, cap_mvalid;
    logic [15:0] cap_addr, cap_ipc, cap_instr, cap_mdata;

    // One clock: compare at negedge, then advance model and memory after posedge
    task automatic tick();
        bit          e_req, e_iv;
        logic [15:0] e_ipc, e_ins;
        bit          c_valid, c_redir, c_ready, c_rst;
        logic [15:0] c_data, c_rpc;
        @(negedge clk);
        c_valid = imem_valid; c_data = imem_data; c_redir = redirect;
        c_rpc = redirect_pc; c_ready = instr_ready; c_rst = rst;
        e_req = !c_rst && !c_redir && !m_halt && (!m_sq || c_valid) && (!m_out || c_valid)
                && ((q.size() + int'(m_out)) < int'(DEPTH)) && !(c_valid && c_data[15:12] == HLT_OP);
        e_iv  = q.size() > 0;
        e_ipc = e_iv ? q[0].pc : 16'h0;
        e_ins = e_iv ? q[0].instr : 16'h0;
        check("imem_req", imem_req, e_req);
        if (e_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", instr_valid, e_iv);
        check("instr_pc", instr_pc, e_ipc);
        check("instr", instr, e_ins);
        cap_req = imem_req; cap_addr = imem_addr; cap_ivalid = instr_valid;
        cap_ipc = instr_pc; cap_instr = instr; cap_mvalid = c_valid; cap_mdata = c_data;
        @(posedge clk);
        #1;
        if (c_rst) begin
            model_reset();
        end else if (c_redir) begin
            q.delete();
            m_pc   = c_rpc;
            m_halt = 0;
            if (m_out && !c_valid) m_sq = 1;
            else begin m_sq = 0; m_out = 0; end
        end else begin
            if (q.size() > 0 && c_ready) void'(q.pop_front());
            if (c_valid && m_out && !m_sq) begin
                q.push_back(fetch_entry_t'{pc: m_opc, instr: c_data});
                if (c_data[15:12] == HLT_OP) m_halt = 1;
            end
            if (c_valid && m_sq) m_sq = 0;
            if (e_req) begin
                m_opc = m_pc;
                m_pc  = m_pc + 16'd2;
                m_out = 1;
            end else if (c_valid) begin
                m_out = 0;
            end
        end
        imem_valid = 1'b0;
        imem_data  = '0;
        if (rst) begin
            mbusy = 0;
        end else begin
            if (cap_req) begin
                mbusy = 1;
                mrem  = rand_lat ? int'($urandom_range(1, 4)) : lat;
                maddr = cap_addr;
            end
            if (mbusy) begin
                mrem--;
                if (mrem == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_word(maddr);
                    mbusy      = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_valid = 1'b0; mbusy = 0;
        model_reset();
        tick();
        tick();
        check("rst_imem_req", cap_req, 1'b0);
        check("rst_instr_valid", cap_ivalid, 1'b0);
        check("rst_instr_pc", cap_ipc, 16'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          restart;
        bit          ready;
        bit          e_req;
        logic [15:0] e_addr;
        bit          e_iv;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int reqs;
        // Streaming with 1-cycle memory, then a decode stall filling the queue
        vt[0]  = '{1, 1, 1, 16'h0000, 0, 16'h0000};
        vt[1]  = '{0, 1, 1, 16'h0002, 0, 16'h0000};
        vt[2]  = '{0, 1, 1, 16'h0004, 1, 16'h0000};
        vt[3]  = '{0, 1, 1, 16'h0006, 1, 16'h0002};
        vt[4]  = '{1, 0, 1, 16'h0000, 0, 16'h0000};
        vt[5]  = '{0, 0, 1, 16'h0002, 0, 16'h0000};
        vt[6]  = '{0, 0, 1, 16'h0004, 1, 16'h0000};
        vt[7]  = '{0, 0, 1, 16'h0006, 1, 16'h0000};
        vt[8]  = '{0, 0, 0, 16'h0000, 1, 16'h0000};
        vt[9]  = '{0, 0, 0, 16'h0000, 1, 16'h0000};
        vt[10] = '{0, 1, 0, 16'h0000, 1, 16'h0000};
        vt[11] = '{0, 1, 1, 16'h0008, 1, 16'h0002};

        model_reset();
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].restart) do_reset();
            instr_ready = vt[i].ready;
            tick();
            check($sformatf("vec%0d_req", i), cap_req, vt[i].e_req);
            if (vt[i].e_req) check($sformatf("vec%0d_addr", i), cap_addr, vt[i].e_addr);
            check($sformatf("vec%0d_valid", i), cap_ivalid, vt[i].e_iv);
            check($sformatf("vec%0d_pc", i), cap_ipc, vt[i].e_pc);
        end

        // Redirect while a 3-cycle fetch of 0x0006 is in flight
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(cap_req && cap_addr == 16'h0006) && n < 100);
        check("reach_req_0006", {15'h0, cap_req} & {16'h0, cap_addr == 16'h0006}, 1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        tick();
        check("redir_r1_valid", cap_ivalid, 1'b0);
        check("redir_r1_req", cap_req, 1'b0);
        n = 0;
        while (!cap_mvalid && n < 10) begin tick(); n++; end
        check("squash_resp_seen", cap_mvalid, 1'b1);
        check("squash_new_req", cap_req, 1'b1);
        check("squash_new_addr", cap_addr, 16'h0040);
        check("squash_dropped", cap_ivalid, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!cap_ivalid && n < 20);
        check("redir_first_pc", cap_ipc, 16'h0040);

        // HLT at 0x0008 stops fetching until a redirect
        lat = 1; hlt_addr = 16'h0008;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (!(cap_mvalid && cap_mdata == 16'hF000) && n < 50);
        check("hlt_resp_req", cap_req, 1'b0);
        tick();
        check("hlt_pushed_valid", cap_ivalid, 1'b1);
        check("hlt_pushed_pc", cap_ipc, 16'h0008);
        check("hlt_pushed_instr", cap_instr, 16'hF000);
        reqs = 0;
        for (int i = 0; i < 6; i++) begin tick(); reqs += int'(cap_req); end
        check("halted_no_req", reqs, 0);
        hlt_addr = 16'h0001;
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        tick();
        check("resume_req", cap_req, 1'b1);
        check("resume_addr", cap_addr, 16'h0010);

        // PC wrap-around
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_addr_fffe", cap_addr, 16'hFFFE);
        tick();
        check("wrap_addr_0000", cap_addr, 16'h0000);

        // Asynchronous reset with three queued entries
        do_reset();
        instr_ready = 1'b0;
        n = 0;
        while (q.size() != 3 && n < 20) begin tick(); n++; end
        check("fifo_three", q.size(), 3);
        check("pre_rst_valid", instr_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", instr_valid, 1'b0);
        check("async_rst_pc", instr_pc, 16'h0);
        check("async_rst_req", imem_req, 1'b0);
        model_reset();
        tick();
        rst = 1'b0;
        imem_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("post_rst_req", cap_req, 1'b1);
        check("post_rst_addr", cap_addr, RESET_PC);

        // Randomized traffic against the model
        rand_lat = 1; hlt_addr = 16'h0020;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom_range(0, 40) * 2);
            tick();
        end
        redirect = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
